// File: rtl/multiword_add_sequencer_pkg.sv
// Shared definitions for the multi-word add/subtract sequencer: word width,
// FSM state encoding and the single-bit full-adder helper.
package multiword_add_sequencer_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Returns {carry_out, sum_bit}
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic [1:0] r;
        r[0] = a ^ b ^ c;
        r[1] = (a & b) | (c & (a ^ b));
        return r;
    endfunction

endpackage

// File: rtl/multiword_add_sequencer_if.sv
// Request/result bus of the multi-word add/subtract sequencer.
// overflow/zero exist only when MWADD_FLAGS_EN is defined.
interface multiword_add_sequencer_if
    import multiword_add_sequencer_pkg::*;
#(
    parameter int NUM_WORDS = 4
) ();
    localparam int W = WORD_W * NUM_WORDS;

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic         Cin;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         Cout;
    logic         busy;
`ifdef MWADD_FLAGS_EN
    logic         overflow;
    logic         zero;
`endif

    modport master (
        output in_valid, op_sub, Cin, A, B, out_ready,
`ifdef MWADD_FLAGS_EN
        input  overflow, zero,
`endif
        input  in_ready, out_valid, sum, Cout, busy
    );

    modport slave (
        input  in_valid, op_sub, Cin, A, B, out_ready,
`ifdef MWADD_FLAGS_EN
        output overflow, zero,
`endif
        output in_ready, out_valid, sum, Cout, busy
    );

endinterface

// File: rtl/multiword_add_sequencer_adder.sv
// 16-bit ripple-carry adder shared by every word of a multi-word operation.
module ripple_carry_adder16bit
    import multiword_add_sequencer_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_cin,
    output logic [WORD_W-1:0] o_sum,
    output logic              o_cout
);

    // Carry ripples LSB to MSB through one full adder per bit
    always_comb begin
        logic       v_c;
        logic [1:0] v_fa;
        o_sum = '0;
        v_c   = i_cin;
        for (int i = 0; i < WORD_W; i++) begin
            v_fa     = full_add(i_a[i], i_b[i], v_c);
            o_sum[i] = v_fa[0];
            v_c      = v_fa[1];
        end
        o_cout = v_c;
    end

endmodule

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract controller: one word per cycle, LSW first, through a
// single shared 16-bit adder. Optional overflow/zero flags under MWADD_FLAGS_EN.
module multiword_add_sequencer
    import multiword_add_sequencer_pkg::*;
#(
    parameter int NUM_WORDS = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multiword_add_sequencer_if.slave    bus
);
    localparam int W     = WORD_W * NUM_WORDS;
    localparam int IDX_W = $clog2(NUM_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b_eff;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               r_cout;
    logic [IDX_W-1:0]   r_idx;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic               w_accept;
    logic               w_last;
    logic [WORD_W-1:0]  w_a_word;
    logic [WORD_W-1:0]  w_b_word;
    logic [WORD_W-1:0]  w_word_sum;
    logic               w_word_cout;

    assign w_accept = bus.in_valid && r_in_ready;
    assign w_last   = (r_idx == LAST_IDX);
    assign w_a_word = r_a[int'(r_idx) * WORD_W +: WORD_W];
    assign w_b_word = r_b_eff[int'(r_idx) * WORD_W +: WORD_W];

    ripple_carry_adder16bit u_adder (
        .i_a    (w_a_word),
        .i_b    (w_b_word),
        .i_cin  (r_carry),
        .o_sum  (w_word_sum),
        .o_cout (w_word_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake/status outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    // Operand capture and per-word accumulation; subtraction is A + ~B + 1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b_eff <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= bus.A;
            r_b_eff <= bus.op_sub ? ~bus.B : bus.B;
            r_sum   <= '0;
            r_carry <= bus.op_sub ? 1'b1 : bus.Cin;
            r_cout  <= 1'b0;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_sum[int'(r_idx) * WORD_W +: WORD_W] <= w_word_sum;
            r_carry <= w_word_cout;
            if (w_last) begin
                r_cout <= w_word_cout;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_sum <= r_sum;
        end
    end

`ifdef MWADD_FLAGS_EN
    logic r_overflow;
    logic r_zero;

    // Zero is an AND of per-word zero terms; overflow is resolved on the top word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_accept) begin
            r_overflow <= 1'b0;
            r_zero     <= 1'b1;
        end else if (r_state == ST_RUN) begin
            r_zero <= r_zero && (w_word_sum == {WORD_W{1'b0}});
            if (w_last) begin
                r_overflow <= (r_a[W-1] == r_b_eff[W-1]) && (w_word_sum[WORD_W-1] != r_a[W-1]);
            end else begin
                r_overflow <= 1'b0;
            end
        end else begin
            r_zero <= r_zero;
        end
    end

    assign bus.overflow = r_overflow;
    assign bus.zero     = r_zero;
`endif

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;
    assign bus.sum       = r_sum;
    assign bus.Cout      = r_cout;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed scoreboard bench for multiword_add_sequencer (NUM_WORDS=4).
module tb_multiword_add_sequencer;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    exp_t sb[$];
    exp_t cur;

    multiword_add_sequencer_if #(.NUM_WORDS(4)) bus_if ();

    multiword_add_sequencer #(.NUM_WORDS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request at the next negedge and let the following posedge accept it
    task automatic start_op(input logic sub, input logic cin, input logic [63:0] a, input logic [63:0] b);
        logic [63:0] b_eff;
        logic [64:0] full;
        exp_t        e;
        @(negedge clk);
        check("in_ready_idle", 64'(bus_if.in_ready), 64'd1);
        b_eff  = sub ? ~b : b;
        full   = {1'b0, a} + {1'b0, b_eff} + 65'(sub ? 1'b1 : cin);
        e.sum  = full[63:0];
        e.cout = full[64];
        e.ovf  = (a[63] == b_eff[63]) && (full[63] != a[63]);
        e.zero = (full[63:0] == 64'd0);
        sb.push_back(e);
        bus_if.in_valid = 1'b1;
        bus_if.op_sub   = sub;
        bus_if.Cin      = cin;
        bus_if.A        = a;
        bus_if.B        = b;
        @(posedge clk);
        #1;
        bus_if.in_valid = 1'b0;
        bus_if.A        = $urandom();
        bus_if.B        = $urandom();
        check("busy_after_accept", 64'(bus_if.busy), 64'd1);
        check("in_ready_after_accept", 64'(bus_if.in_ready), 64'd0);
    endtask

    // Wait for out_valid, check latency and result against the scoreboard head
    task automatic wait_result(input string tag);
        int cyc;
        cyc = 1;
        while (bus_if.out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1;
            if (bus_if.out_valid !== 1'b1) cyc++;
        end
        if (bus_if.out_valid !== 1'b1) begin
            check({tag, "_timeout"}, 64'(bus_if.out_valid), 64'd1);
        end else begin
            check({tag, "_latency"}, 64'(cyc), 64'd4);
            cur = sb.pop_front();
            check({tag, "_sum"}, bus_if.sum, cur.sum);
            check({tag, "_cout"}, 64'(bus_if.Cout), 64'(cur.cout));
`ifdef MWADD_FLAGS_EN
            check({tag, "_ovf"}, 64'(bus_if.overflow), 64'(cur.ovf));
            check({tag, "_zero"}, 64'(bus_if.zero), 64'(cur.zero));
`endif
        end
    endtask

    task automatic release_result(input string tag);
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b0;
        check({tag, "_ov_drop"}, 64'(bus_if.out_valid), 64'd0);
        check({tag, "_ir_back"}, 64'(bus_if.in_ready), 64'd1);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.op_sub    = 1'b0;
        bus_if.Cin       = 1'b0;
        bus_if.A         = 64'd0;
        bus_if.B         = 64'd0;
        bus_if.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(bus_if.in_ready), 64'd1);
        check("rst_out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rst_busy", 64'(bus_if.busy), 64'd0);
        check("rst_sum", bus_if.sum, 64'd0);
        check("rst_cout", 64'(bus_if.Cout), 64'd0);
`ifdef MWADD_FLAGS_EN
        check("rst_ovf", 64'(bus_if.overflow), 64'd0);
        check("rst_zero", 64'(bus_if.zero), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Carry propagates across the word boundary
        start_op(1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1);
        wait_result("t1");
        release_result("t1");

        // Carry-in ripples through every word
        start_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
        wait_result("t2");
        release_result("t2");

        start_op(1'b1, 1'b0, 64'd5, 64'd7);
        wait_result("t3");
        release_result("t3");

        start_op(1'b0, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        wait_result("t4");
        release_result("t4");

        // Consumer stalls while a new request is offered
        start_op(1'b0, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444);
        wait_result("t5");
        @(negedge clk);
        bus_if.in_valid = 1'b1;
        bus_if.A        = 64'hAAAA_0000_5555_0000;
        bus_if.B        = 64'h0000_1111_0000_2222;
        for (int h = 0; h < 3; h++) begin
            @(posedge clk);
            #1;
            check("t5_hold_sum", bus_if.sum, cur.sum);
            check("t5_hold_cout", 64'(bus_if.Cout), 64'(cur.cout));
            check("t5_hold_ov", 64'(bus_if.out_valid), 64'd1);
            check("t5_hold_ir", 64'(bus_if.in_ready), 64'd0);
        end
        bus_if.in_valid = 1'b0;
        release_result("t5");
        check("t5_not_queued_busy", 64'(bus_if.busy), 64'd0);
        start_op(1'b0, 1'b0, 64'hAAAA_0000_5555_0000, 64'h0000_1111_0000_2222);
        wait_result("t5b");
        release_result("t5b");

        // Asynchronous reset two cycles into RUN discards the partial result
        start_op(1'b1, 1'b0, 64'h0123_4567_89AB_CDEF, 64'h0000_0000_0000_0001);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        void'(sb.pop_back());
        #1;
        check("t6_ov", 64'(bus_if.out_valid), 64'd0);
        check("t6_sum", bus_if.sum, 64'd0);
        check("t6_busy", 64'(bus_if.busy), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        start_op(1'b0, 1'b1, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001);
        wait_result("t6b");
        release_result("t6b");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
